bus_arbiter: RTL
================

Name: bus_arbiter

Overview:
- Shares the CPU's single 8-bit common data bus between several bus masters: microcode sequencer, debug/loader port, interrupt unit, and spare.
- Issues a registered one-hot grant using round-robin priority, with a hold limit and a lock override.
- Inserts one idle turnaround cycle between owners. During that cycle the bus carries zero, so two drivers never overlap.
- Sits between the masters' source muxes and the bus consumers: IR, PC, RF, ALU source latches.

Parameters:
- NUM_REQ, 4, number of requesters; power of two, 2..8; ID_W = clog2(NUM_REQ).
- DATA_W, 8, bus width.
- MAX_HOLD, 8, cycles an unlocked owner may hold the bus while another requester waits; range 1..255.

Ports:
- clock, input, 1, system clock; all state updates on the rising edge.
- reset_n, input, 1, synchronous active-low reset, sampled on the rising edge of clock.
- req, input, NUM_REQ, per-requester bus request; level-sensitive.
- lock, input, NUM_REQ, per-requester hold-limit override; ignored unless the matching req bit is high and that requester is the owner.
- src_data, input, NUM_REQ*DATA_W, requester i drives bits [i*DATA_W +: DATA_W].
- grant, output, NUM_REQ, registered one-hot grant; all zero when no owner.
- grant_valid, output, 1, high while some requester owns the bus.
- grant_id, output, ID_W, index of the owner; holds the last owner when grant_valid is 0.
- bus_data, output, DATA_W, src_data slice of the owner when grant_valid, else 0.
- timeout_pulse, output, 1, one-cycle pulse on a forced release.

Behaviour:
- State register with three states: IDLE, BUSY, TURN.
- Registers: owner id, round-robin pointer last_id, hold counter hold_cnt (saturating at MAX_HOLD), timeout_pulse.
- Reset (reset_n low at a clock edge), which also applies mid-transfer and takes effect the same edge:
  - state = IDLE, grant = 0, grant_valid = 0, grant_id = 0, timeout_pulse = 0, hold_cnt = 0.
  - last_id = NUM_REQ-1, so requester 0 has top priority after reset.
- Arbitration function: the first set req bit scanning last_id+1, last_id+2, … modulo NUM_REQ.
- IDLE:
  - If any req is set, go to BUSY. Owner = arbitration winner, hold_cnt = 0, last_id = winner.
  - Latency: req sampled high at edge t gives grant at edge t+1.
  - Otherwise stay in IDLE.
- BUSY, evaluated each cycle in this order:
  - req[owner] = 0: go to TURN (voluntary release, no pulse).
  - Else, if lock[owner] = 0, hold_cnt = MAX_HOLD, and any other req bit is set: go to TURN and set timeout_pulse for exactly one cycle (forced release).
  - Else stay in BUSY; hold_cnt increments, saturating at MAX_HOLD.
  - A lone requester holds indefinitely; its counter sits at MAX_HOLD.
  - lock keeps the owner indefinitely; hold_cnt still counts.
  - Dropping lock while hold_cnt = MAX_HOLD and another requester is waiting releases the bus on the next edge.
- TURN (one cycle):
  - grant = 0, grant_valid = 0, bus_data = 0.
  - Next edge: if any req is set, go to BUSY with a new arbitration (hold_cnt = 0); else go to IDLE.
  - A preempted owner still requesting re-enters arbitration with lowest priority, because last_id = its id.
- Every ownership change passes through TURN. BUSY never switches directly to BUSY with a different owner.
- bus_data is a combinational mux from the registered owner. It is zero whenever grant_valid = 0.
- grant, grant_valid and grant_id are registered and glitch-free.
- Changes to req or lock during TURN affect only the next arbitration.
- Simultaneous requests in IDLE are resolved by round-robin only; there are no fixed priorities.
- Width rules:
  - hold_cnt width = clog2(MAX_HOLD+1).
  - grant_id wraps modulo NUM_REQ (no out-of-range index).

Test Plan:
- Reset/basic grant (NUM_REQ=4, MAX_HOLD=8): release reset, then set req=0001 → grant=0001 and grant_valid=1 one edge later, bus_data = src_data[0] = 8'hA5. Drop req → one TURN cycle with bus_data=0, then IDLE.
- Round-robin: req=1111 held with all owners releasing after 2 cycles → grant order 0,1,2,3,0. Each ownership is separated by exactly one cycle with grant=0000.
- Forced release: req0 and req1 held high, lock=0 → owner 0 for 9 cycles (hold_cnt 0..8). Then timeout_pulse=1 for one cycle, grant=0000 for one cycle, then grant=0010.
- Lock override: req0 and req1 high, lock0 high → grant=0001 stays for 50 cycles with no timeout_pulse. Drop lock0 → TURN, then grant=0010.
- Lone requester: only req2 high for 30 cycles → grant=0100 continuously, timeout_pulse never asserted.
- Mid-operation reset: owner 3 in BUSY, assert reset_n=0 for one edge → next cycle grant=0000, grant_valid=0, timeout_pulse=0. Then req=1001 → grant=0001 (requester 0 wins after reset).

Source files
------------

// File: rtl/bus_arbiter.sv
// Round-robin arbiter for the shared CPU data bus: registered one-hot grant,
// hold limit with lock override, and one idle turnaround cycle between owners.
module bus_arbiter #(
    parameter  int NUM_REQ  = 4,
    parameter  int DATA_W   = 8,
    parameter  int MAX_HOLD = 8,
    localparam int ID_W     = $clog2(NUM_REQ),
    localparam int HOLD_W   = $clog2(MAX_HOLD + 1)
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ-1:0]          lock,
    input  logic [NUM_REQ*DATA_W-1:0]   src_data,
    output logic [NUM_REQ-1:0]          grant,
    output logic                        grant_valid,
    output logic [ID_W-1:0]             grant_id,
    output logic [DATA_W-1:0]           bus_data,
    output logic                        timeout_pulse
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] TURN = 2'd2;

    localparam logic [HOLD_W-1:0]  HOLD_LIMIT = HOLD_W'(MAX_HOLD);
    localparam logic [HOLD_W-1:0]  HOLD_ONE   = HOLD_W'(1);
    localparam logic [NUM_REQ-1:0] GRANT_ONE  = {{(NUM_REQ-1){1'b0}}, 1'b1};

    logic [1:0]         state_r, state_s;
    logic [NUM_REQ-1:0] grant_r, grant_s;
    logic               grant_valid_r, grant_valid_s;
    logic [ID_W-1:0]    grant_id_r, grant_id_s;
    logic [ID_W-1:0]    last_id_r, last_id_s;
    logic [HOLD_W-1:0]  hold_cnt_r, hold_cnt_s;
    logic               timeout_pulse_r, timeout_pulse_s;

    logic               win_found_s;
    logic [ID_W-1:0]    win_id_s;
    logic [ID_W-1:0]    scan_id_s;
    logic               others_s;

    // Round-robin winner: scan downward so the nearest index after last_id is assigned last and wins
    always_comb begin
        win_found_s = 1'b0;
        win_id_s    = last_id_r;
        scan_id_s   = last_id_r;
        for (int i = NUM_REQ; i >= 1; i--) begin
            scan_id_s = last_id_r + ID_W'(i);
            if (req[scan_id_s]) begin
                win_found_s = 1'b1;
                win_id_s    = scan_id_s;
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

    assign others_s = |(req & ~grant_r);

    // Next-state logic for ownership, hold counter and timeout pulse
    always_comb begin
        state_s         = state_r;
        grant_s         = grant_r;
        grant_valid_s   = grant_valid_r;
        grant_id_s      = grant_id_r;
        last_id_s       = last_id_r;
        hold_cnt_s      = hold_cnt_r;
        timeout_pulse_s = 1'b0;
        case (state_r)
            IDLE, TURN: begin
                if (win_found_s) begin
                    state_s       = BUSY;
                    grant_s       = GRANT_ONE << win_id_s;
                    grant_valid_s = 1'b1;
                    grant_id_s    = win_id_s;
                    last_id_s     = win_id_s;
                    hold_cnt_s    = {HOLD_W{1'b0}};
                end else begin
                    state_s       = IDLE;
                    grant_s       = {NUM_REQ{1'b0}};
                    grant_valid_s = 1'b0;
                end
            end
            BUSY: begin
                if (!req[grant_id_r]) begin
                    state_s       = TURN;
                    grant_s       = {NUM_REQ{1'b0}};
                    grant_valid_s = 1'b0;
                end else if (!lock[grant_id_r] && (hold_cnt_r == HOLD_LIMIT) && others_s) begin
                    state_s         = TURN;
                    grant_s         = {NUM_REQ{1'b0}};
                    grant_valid_s   = 1'b0;
                    timeout_pulse_s = 1'b1;
                end else if (hold_cnt_r != HOLD_LIMIT) begin
                    hold_cnt_s = hold_cnt_r + HOLD_ONE;
                end else begin
                    hold_cnt_s = hold_cnt_r;
                end
            end
            default: begin
                state_s       = IDLE;
                grant_s       = {NUM_REQ{1'b0}};
                grant_valid_s = 1'b0;
            end
        endcase
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_r         <= IDLE;
            grant_r         <= {NUM_REQ{1'b0}};
            grant_valid_r   <= 1'b0;
            grant_id_r      <= {ID_W{1'b0}};
            last_id_r       <= ID_W'(NUM_REQ - 1);
            hold_cnt_r      <= {HOLD_W{1'b0}};
            timeout_pulse_r <= 1'b0;
        end else begin
            state_r         <= state_s;
            grant_r         <= grant_s;
            grant_valid_r   <= grant_valid_s;
            grant_id_r      <= grant_id_s;
            last_id_r       <= last_id_s;
            hold_cnt_r      <= hold_cnt_s;
            timeout_pulse_r <= timeout_pulse_s;
        end
    end

    // Bus mux driven only from registered ownership so it is zero during turnaround
    always_comb begin
        if (grant_valid_r) begin
            bus_data = src_data[grant_id_r * DATA_W +: DATA_W];
        end else begin
            bus_data = {DATA_W{1'b0}};
        end
    end

    assign grant         = grant_r;
    assign grant_valid   = grant_valid_r;
    assign grant_id      = grant_id_r;
    assign timeout_pulse = timeout_pulse_r;

endmodule
